reg_bank_arbiter: RTL and testbench

Two-master access controller for the VT100 register bank. Arbitrates round-robin between two requesters, decodes the address into one-hot `reg_wr_sel` strobes with a shared `reg_wr_rd`/`reg_wr_data` bus, and returns the read data with an ack pulse. Sits between the host/internal bus adapters and the register instances (e.g. `reg_register_int_mask`).

---
 rtl/reg_bank_arb_pkg.sv | 13 +
 rtl/reg_bank_arbiter_if.sv | 46 ++++
 rtl/reg_bank_arb_rr.sv | 21 ++
 rtl/reg_bank_arbiter.sv | 162 ++++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_bank_arb_pkg.sv
// rtl/reg_bank_arb_pkg.sv - FSM state type and grant index constants for reg_bank_arbiter
package reg_bank_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// rtl/reg_bank_arbiter_if.sv - two-master request/response bus plus register bank strobe/readback bus
interface reg_bank_arbiter_if #(
    parameter int REG_WIDTH  = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int REG_NUM    = 16
);
    logic                         m0_req;
    logic                         m0_wr;
    logic [ADDR_WIDTH-1:0]        m0_addr;
    logic [REG_WIDTH-1:0]         m0_wdata;
    logic                         m0_ack;
    logic [REG_WIDTH-1:0]         m0_rdata;
    logic                         m0_err;

    logic                         m1_req;
    logic                         m1_wr;
    logic [ADDR_WIDTH-1:0]        m1_addr;
    logic [REG_WIDTH-1:0]         m1_wdata;
    logic                         m1_ack;
    logic [REG_WIDTH-1:0]         m1_rdata;
    logic                         m1_err;

    logic [REG_NUM-1:0]           reg_wr_sel;
    logic                         reg_wr_rd;
    logic [REG_WIDTH-1:0]         reg_wr_data;
    logic [REG_NUM*REG_WIDTH-1:0] reg_rd_bus;

    modport slave (
        input  m0_req, m0_wr, m0_addr, m0_wdata,
        input  m1_req, m1_wr, m1_addr, m1_wdata,
        input  reg_rd_bus,
        output m0_ack, m0_rdata, m0_err,
        output m1_ack, m1_rdata, m1_err,
        output reg_wr_sel, reg_wr_rd, reg_wr_data
    );

    modport master (
        output m0_req, m0_wr, m0_addr, m0_wdata,
        output m1_req, m1_wr, m1_addr, m1_wdata,
        output reg_rd_bus,
        input  m0_ack, m0_rdata, m0_err,
        input  m1_ack, m1_rdata, m1_err,
        input  reg_wr_sel, reg_wr_rd, reg_wr_data
    );

endinterface

// File: rtl/reg_bank_arb_rr.sv
// rtl/reg_bank_arb_rr.sv - combinational 2-way round-robin picker; pointer register lives in the parent
module reg_bank_arb_rr (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_idx
);
    import reg_bank_arb_pkg::*;

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = GNT_M0;
        // On a conflict the loser of the previous grant wins
        if (req == 2'b11) begin
            gnt_idx = ~last_grant;
        end else if (req[1]) begin
            gnt_idx = GNT_M1;
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - two-master round-robin access controller for the register bank
// Optional address-range error reporting: define REG_BANK_ARB_ADDR_CHK_EN.
module reg_bank_arbiter #(
    parameter int REG_WIDTH  = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int REG_NUM    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    reg_bank_arbiter_if.slave  bus
);
    import reg_bank_arb_pkg::*;

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic                    w_take;

    logic                    r_last_grant;
    logic                    r_gnt;
    logic                    r_wr;
    logic [ADDR_WIDTH-1:0]   r_addr;

    logic                    w_gnt_valid;
    logic                    w_gnt_idx;
    logic                    w_req_wr;
    logic [ADDR_WIDTH-1:0]   w_req_addr;
    logic [REG_WIDTH-1:0]    w_req_wdata;
    logic [REG_WIDTH-1:0]    w_lat_slice;
    logic [REG_WIDTH-1:0]    w_rd_value;

    logic [REG_NUM-1:0]      r_sel;
    logic                    r_wr_rd;
    logic [REG_WIDTH-1:0]    r_wr_data;
    logic [1:0]              r_ack;
    logic [REG_WIDTH-1:0]    r_rdata0;
    logic [REG_WIDTH-1:0]    r_rdata1;

    // Addresses at or above REG_NUM decode to an all-zero select
    function automatic logic [REG_NUM-1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [REG_NUM-1:0] sel;
        for (int i = 0; i < REG_NUM; i++) begin
            sel[i] = (addr == ADDR_WIDTH'(i));
        end
        return sel;
    endfunction

    reg_bank_arb_rr u_rr (
        .req        ({bus.m1_req, bus.m0_req}),
        .last_grant (r_last_grant),
        .gnt_valid  (w_gnt_valid),
        .gnt_idx    (w_gnt_idx)
    );

    assign w_req_wr    = (w_gnt_idx == GNT_M1) ? bus.m1_wr    : bus.m0_wr;
    assign w_req_addr  = (w_gnt_idx == GNT_M1) ? bus.m1_addr  : bus.m0_addr;
    assign w_req_wdata = (w_gnt_idx == GNT_M1) ? bus.m1_wdata : bus.m0_wdata;

    always_comb begin
        w_lat_slice = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            if (r_addr == ADDR_WIDTH'(i)) begin
                w_lat_slice = bus.reg_rd_bus[i*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    assign w_rd_value = r_wr ? '0 : w_lat_slice;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_state_nxt = ACCESS;
                    w_take      = 1'b1;
                end
            end
            ACCESS:  w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Strobes are loaded on the grant edge so they are visible for exactly the ACCESS cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= GNT_M1;
            r_gnt        <= GNT_M0;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_sel        <= '0;
            r_wr_rd      <= 1'b0;
            r_wr_data    <= '0;
            r_ack        <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_sel     <= '0;
            r_wr_rd   <= 1'b0;
            r_wr_data <= '0;
            r_ack     <= '0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            if (w_take) begin
                r_gnt        <= w_gnt_idx;
                r_last_grant <= w_gnt_idx;
                r_wr         <= w_req_wr;
                r_addr       <= w_req_addr;
                r_sel        <= decode(w_req_addr);
                r_wr_rd      <= w_req_wr;
                r_wr_data    <= w_req_wdata;
            end
            if (r_state == ACCESS) begin
                r_ack[r_gnt] <= 1'b1;
                if (r_gnt == GNT_M0) begin
                    r_rdata0 <= w_rd_value;
                end else begin
                    r_rdata1 <= w_rd_value;
                end
            end
        end
    end

`ifdef REG_BANK_ARB_ADDR_CHK_EN
    logic [1:0] r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= '0;
        end else begin
            r_err <= '0;
            if (r_state == ACCESS) begin
                r_err[r_gnt] <= ~|decode(r_addr);
            end
        end
    end

    assign bus.m0_err = r_err[0];
    assign bus.m1_err = r_err[1];
`else
    assign bus.m0_err = 1'b0;
    assign bus.m1_err = 1'b0;
`endif

    assign bus.m0_ack      = r_ack[0];
    assign bus.m1_ack      = r_ack[1];
    assign bus.m0_rdata    = r_rdata0;
    assign bus.m1_rdata    = r_rdata1;
    assign bus.reg_wr_sel  = r_sel;
    assign bus.reg_wr_rd   = r_wr_rd;
    assign bus.reg_wr_data = r_wr_data;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb/tb_reg_bank_arbiter.sv - directed and randomized self-checking bench for reg_bank_arbiter
module tb_reg_bank_arbiter;

    localparam int RW = 32;
    localparam int AW = 4;
    localparam int RN = 8;
`ifdef REG_BANK_ARB_ADDR_CHK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    reg_bank_arbiter_if #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .REG_NUM(RN)) bus ();

    reg_bank_arbiter #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .REG_NUM(RN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RN-1:0] sel;
        logic          wr_rd;
        logic [RW-1:0] wr_data;
        logic [1:0]    ack;
        logic [1:0]    err;
        logic [RW-1:0] rd0;
        logic [RW-1:0] rd1;
    } exp_t;

    // Expected outputs per post-edge window, indexed by edge number modulo 8
    exp_t exp_q [8];
    int   edge_cnt   = 0;
    int   free_at    = 0;
    logic last_grant = 1'b1;
    bit   rd_pend    = 1'b0;
    int   rd_cyc     = 0;
    int   rd_addr    = 0;
    logic rd_m       = 1'b0;
    bit   chk_en     = 1'b0;
    int   n_err      = 0;
    int   n_chk      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        int   k;
        logic g;
        int   addr;
        edge_cnt++;
        k = edge_cnt;
        exp_q[(k+2)%8] = '0;
        if (!rst_n) begin
            exp_q[k%8]     = '0;
            exp_q[(k+1)%8] = '0;
            free_at        = k + 1;
            last_grant     = 1'b1;
            rd_pend        = 1'b0;
        end else begin
            if (rd_pend && rd_cyc == k) begin
                rd_pend = 1'b0;
                if (rd_addr < RN) begin
                    if (rd_m) exp_q[k%8].rd1 = bus.reg_rd_bus[rd_addr*RW +: RW];
                    else      exp_q[k%8].rd0 = bus.reg_rd_bus[rd_addr*RW +: RW];
                end
            end
            if (k >= free_at && (bus.m0_req || bus.m1_req)) begin
                if (bus.m0_req && bus.m1_req) g = ~last_grant;
                else                          g = bus.m1_req;
                last_grant = g;
                addr = g ? int'(bus.m1_addr) : int'(bus.m0_addr);
                exp_q[k%8].sel     = (addr < RN) ? RN'(1 << addr) : '0;
                exp_q[k%8].wr_rd   = g ? bus.m1_wr : bus.m0_wr;
                exp_q[k%8].wr_data = g ? bus.m1_wdata : bus.m0_wdata;
                exp_q[(k+1)%8].ack[g] = 1'b1;
                exp_q[(k+1)%8].err[g] = CHK && (addr >= RN);
                if (!(g ? bus.m1_wr : bus.m0_wr)) begin
                    rd_pend = 1'b1;
                    rd_cyc  = k + 1;
                    rd_addr = addr;
                    rd_m    = g;
                end
                free_at = k + 3;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            e = exp_q[edge_cnt%8];
            check("model reg_wr_sel",  64'(bus.reg_wr_sel),  64'(e.sel));
            check("model reg_wr_rd",   64'(bus.reg_wr_rd),   64'(e.wr_rd));
            check("model reg_wr_data", 64'(bus.reg_wr_data), 64'(e.wr_data));
            check("model m0_ack",      64'(bus.m0_ack),      64'(e.ack[0]));
            check("model m1_ack",      64'(bus.m1_ack),      64'(e.ack[1]));
            check("model m0_err",      64'(bus.m0_err),      64'(e.err[0]));
            check("model m1_err",      64'(bus.m1_err),      64'(e.err[1]));
            check("model m0_rdata",    64'(bus.m0_rdata),    64'(e.rd0));
            check("model m1_rdata",    64'(bus.m1_rdata),    64'(e.rd1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nedge();
        @(negedge clk);
    endtask

    initial begin
        logic [11:0] a0_seq;
        logic [11:0] a1_seq;
        logic        a0;
        logic        a1;
        foreach (exp_q[i]) exp_q[i] = '0;
        bus.m0_req = 1'b0; bus.m0_wr = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_wr = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
        bus.reg_rd_bus = '0;
        tick();
        chk_en = 1'b1;
        nedge();
        check("reset sel",   64'(bus.reg_wr_sel), 64'h0);
        check("reset acks",  64'({bus.m0_ack, bus.m1_ack}), 64'h0);
        tick();
        rst_n = 1'b1;

        // single write from m0
        bus.m0_wr = 1'b1; bus.m0_addr = 4'd3; bus.m0_wdata = 32'hA5A5_0001; bus.m0_req = 1'b1;
        nedge();
        check("t1 idle sel", 64'(bus.reg_wr_sel), 64'h0);
        nedge();
        check("t1 sel",      64'(bus.reg_wr_sel),  64'h08);
        check("t1 wr_rd",    64'(bus.reg_wr_rd),   64'h1);
        check("t1 wr_data",  64'(bus.reg_wr_data), 64'hA5A5_0001);
        check("t1 early ack",64'(bus.m0_ack),      64'h0);
        nedge();
        check("t1 m0_ack",   64'(bus.m0_ack), 64'h1);
        check("t1 m0_err",   64'(bus.m0_err), 64'h0);
        check("t1 m1_ack",   64'(bus.m1_ack), 64'h0);
        tick();
        bus.m0_req = 1'b0;

        // single read from m1
        bus.reg_rd_bus = '0;
        bus.reg_rd_bus[5*RW +: RW] = 32'h0000_0001;
        bus.reg_rd_bus[4*RW +: RW] = 32'hDEAD_0004;
        bus.m1_wr = 1'b0; bus.m1_addr = 4'd5; bus.m1_req = 1'b1;
        nedge();
        nedge();
        check("t2 sel",      64'(bus.reg_wr_sel), 64'h20);
        check("t2 wr_rd",    64'(bus.reg_wr_rd),  64'h0);
        nedge();
        check("t2 m1_ack",   64'(bus.m1_ack),   64'h1);
        check("t2 m1_rdata", 64'(bus.m1_rdata), 64'h1);
        check("t2 m0_ack",   64'(bus.m0_ack),   64'h0);
        tick();
        bus.m1_req = 1'b0;

        // simultaneous requests straight out of reset
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        bus.m0_wr = 1'b0; bus.m0_addr = 4'd1; bus.m0_req = 1'b1;
        bus.m1_wr = 1'b1; bus.m1_addr = 4'd2; bus.m1_wdata = 32'h1234_5678; bus.m1_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            nedge();
            a0_seq[i] = bus.m0_ack;
            a1_seq[i] = bus.m1_ack;
        end
        check("t3 m0 ack slots", 64'(a0_seq), 64'h104);
        check("t3 m1 ack slots", 64'(a1_seq), 64'h820);
        tick();
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;

        // out-of-range read
        for (int j = 0; j < RN; j++) bus.reg_rd_bus[j*RW +: RW] = 32'hC0DE_0000 + 32'(j);
        bus.m0_wr = 1'b0; bus.m0_addr = 4'd12; bus.m0_req = 1'b1;
        nedge();
        nedge();
        check("t4 sel",      64'(bus.reg_wr_sel), 64'h0);
        nedge();
        check("t4 m0_ack",   64'(bus.m0_ack),   64'h1);
        check("t4 m0_rdata", 64'(bus.m0_rdata), 64'h0);
        check("t4 m0_err",   64'(bus.m0_err),   64'(CHK));
        tick();
        bus.m0_req = 1'b0;

        // reset while in ACCESS
        bus.m1_wr = 1'b0; bus.m1_addr = 4'd2; bus.m1_req = 1'b1;
        nedge();
        nedge();
        check("t5 access sel", 64'(bus.reg_wr_sel), 64'h04);
        rst_n = 1'b0;
        nedge();
        check("t5 rst sel",  64'(bus.reg_wr_sel), 64'h0);
        check("t5 rst acks", 64'({bus.m0_ack, bus.m1_ack}), 64'h0);
        check("t5 rst data", 64'({bus.reg_wr_rd, bus.m1_rdata}), 64'h0);
        rst_n = 1'b1;
        nedge();
        check("t5 resel",    64'(bus.reg_wr_sel), 64'h04);
        nedge();
        check("t5 m1_ack",   64'(bus.m1_ack),   64'h1);
        check("t5 m1_rdata", 64'(bus.m1_rdata), 64'hC0DE_0002);
        tick();
        bus.m1_req = 1'b0;

        // m0 withdraws during ACCESS, then a conflict goes to m1
        bus.m0_wr = 1'b0; bus.m0_addr = 4'd6; bus.m0_req = 1'b1;
        nedge();
        nedge();
        bus.m0_req = 1'b0;
        nedge();
        check("t6 m0_ack",   64'(bus.m0_ack),   64'h1);
        check("t6 m0_rdata", 64'(bus.m0_rdata), 64'hC0DE_0006);
        tick();
        bus.m0_wr = 1'b1; bus.m0_addr = 4'd7; bus.m0_req = 1'b1;
        bus.m1_wr = 1'b0; bus.m1_addr = 4'd0; bus.m1_req = 1'b1;
        nedge();
        nedge();
        check("t6 rr sel",    64'(bus.reg_wr_sel), 64'h01);
        nedge();
        check("t6 rr m1_ack", 64'(bus.m1_ack), 64'h1);
        check("t6 rr m0_ack", 64'(bus.m0_ack), 64'h0);
        tick();
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;

        // randomized traffic with occasional withdrawals and resets
        for (int c = 0; c < 2000; c++) begin
            nedge();
            a0 = bus.m0_ack;
            a1 = bus.m1_ack;
            tick();
            rst_n = ($urandom_range(0, 149) != 0);
            for (int j = 0; j < RN; j++) bus.reg_rd_bus[j*RW +: RW] = $urandom;
            if (bus.m0_req && (a0 || $urandom_range(0, 29) == 0)) bus.m0_req = 1'b0;
            if (bus.m1_req && (a1 || $urandom_range(0, 29) == 0)) bus.m1_req = 1'b0;
            if (!bus.m0_req && $urandom_range(0, 2) != 0) begin
                bus.m0_req = 1'b1; bus.m0_wr = 1'($urandom);
                bus.m0_addr = AW'($urandom_range(0, 15)); bus.m0_wdata = $urandom;
            end
            if (!bus.m1_req && $urandom_range(0, 2) != 0) begin
                bus.m1_req = 1'b1; bus.m1_wr = 1'($urandom);
                bus.m1_addr = AW'($urandom_range(0, 15)); bus.m1_wdata = $urandom;
            end
        end
        bus.m0_req = 1'b0; bus.m1_req = 1'b0; rst_n = 1'b1;
        repeat (5) tick();
        nedge();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
